rsp_s1_prep_integ: RTL and testbench

- Inverse of the S1 prep differentiator: reconstructs samples from first-difference bursts by running integration, per frame.
- Sits on the reconstruction/verification path after the diff stage.
- Handles three modes:
  - 16-bit lag-2 (I/Q interleaved)
  - 16-bit lag-1
  - 32-bit lag-1, with two 16-bit lanes forming one sample
- Internal accumulation is exact (wide); saturation is applied only on output.

---
 rtl/rsp_s1_prep_pkg.sv | 30 +++
 rtl/rsp_s1_prep_integ_lane_sat.sv | 19 +
 rtl/rsp_s1_prep_integ.sv | 124 ++++++++++++
 tb/tb_rsp_s1_prep_integ.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rsp_s1_prep_pkg.sv
// rsp_s1_prep_pkg: shared modes, saturation limits and the output saturation helper
package rsp_s1_prep_pkg;
  typedef enum logic [1:0] {
    MODE_16_LAG2 = 2'd0,
    MODE_16_LAG1 = 2'd1,
    MODE_32_LAG1 = 2'd2
  } mode_e;

  localparam logic signed [63:0] SAT16_MAX = 64'sh7FFF;
  localparam logic signed [63:0] SAT16_MIN = -64'sh7FFF;
  localparam logic signed [63:0] SAT32_MAX = 64'sh7FFF_FFFF;
  localparam logic signed [63:0] SAT32_MIN = -64'sh7FFF_FFFF;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_res_t;

  // Symmetric clamp of an exact accumulator value to the mode's sample width
  function automatic sat_res_t sat_to_width(input logic signed [63:0] acc, input mode_e mode);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    hi = mode == MODE_32_LAG1 ? SAT32_MAX : SAT16_MAX;
    lo = mode == MODE_32_LAG1 ? SAT32_MIN : SAT16_MIN;
    r.sat = acc > hi || acc < lo;
    r.val = 32'(acc > hi ? hi : acc < lo ? lo : acc);
    return r;
  endfunction
endpackage

// File: rtl/rsp_s1_prep_integ_lane_sat.sv
// rsp_s1_prep_integ_lane_sat: saturates one sample and emits the half belonging to this lane
module rsp_s1_prep_integ_lane_sat
  import rsp_s1_prep_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int LW    = 16,
  parameter int HI    = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  input  mode_e                   mode,
  output logic [LW-1:0]           lane,
  output logic                    sat
);
  sat_res_t r;

  assign r    = sat_to_width(64'(acc), mode);
  assign sat  = r.sat;
  assign lane = HI != 0 && mode == MODE_32_LAG1 ? r.val[LW +: LW] : r.val[LW-1:0];
endmodule

// File: rtl/rsp_s1_prep_integ.sv
// rsp_s1_prep_integ: running-sum reconstruction of first-difference bursts, per frame
module rsp_s1_prep_integ
  import rsp_s1_prep_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32,
  parameter int BURST_LEN    = 8,
  parameter int DATA_NUM     = 1024,
  parameter int ACC_W        = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_sel_16_32,
  input  logic                      i_switch,
  input  logic [SAMPLE_WIDTH/2-1:0] i_d_data [BURST_LEN],
  input  logic                      i_d_valid,
  input  logic                      i_d_last,
  output logic [SAMPLE_WIDTH/2-1:0] o_y [BURST_LEN],
  output logic                      o_y_valid,
  output logic                      o_y_last,
  output logic                      o_sat,
  output logic                      o_frame_err
);
  localparam int LW = SAMPLE_WIDTH / 2;
  localparam int HB = BURST_LEN / 2;
  localparam int CW = DATA_NUM > 1 ? $clog2(DATA_NUM) : 1;
  localparam int IW = $clog2(BURST_LEN);

  mode_e                   mode_q, m_in, m1, s1_mode;
  logic [CW-1:0]           cnt;
  logic                    first, at_end, wrap, lag2;
  logic                    s1_valid, s1_last, s1_err, s1_first;
  logic [IW-1:0]           idx;
  logic signed [ACC_W-1:0] x [BURST_LEN];
  logic signed [ACC_W-1:0] p [BURST_LEN];
  logic signed [ACC_W-1:0] s1_p [BURST_LEN];
  logic signed [ACC_W-1:0] y [BURST_LEN];
  logic signed [ACC_W-1:0] cl1, cl2;
  logic [LW-1:0]           yo [BURST_LEN];
  logic [BURST_LEN-1:0]    ss;

  assign first  = cnt == '0;
  assign at_end = cnt == CW'(DATA_NUM - 1);
  assign wrap   = i_d_last || at_end;
  assign m_in   = i_sel_16_32 ? MODE_32_LAG1 : i_switch ? MODE_16_LAG1 : MODE_16_LAG2;
  assign m1     = first ? m_in : mode_q;

  // Beat position within the frame; the mode is captured on each frame's first beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      mode_q <= MODE_16_LAG2;
    end else if (i_d_valid) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (first) mode_q <= m_in;
    end

  // Sign-extend lanes (paired in 32-bit mode) and form intra-beat lagged prefix sums
  always_comb begin
    for (int i = 0; i < BURST_LEN; i++) x[i] = m1 == MODE_32_LAG1 ? '0 : ACC_W'($signed(i_d_data[i]));
    if (m1 == MODE_32_LAG1)
      for (int k = 0; k < HB; k++) x[k] = ACC_W'($signed({i_d_data[2*k+1], i_d_data[2*k]}));
    p = x;
    for (int i = 1; i < BURST_LEN; i++) if (m1 != MODE_16_LAG2) p[i] = x[i] + p[i-1];
    for (int i = 2; i < BURST_LEN; i++) if (m1 == MODE_16_LAG2) p[i] = x[i] + p[i-2];
  end

  // Stage 1 register: prefix sums plus the beat's framing context
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_p     <= '{default: '0};
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_err   <= 1'b0;
      s1_first <= 1'b0;
      s1_mode  <= MODE_16_LAG2;
    end else begin
      s1_valid <= i_d_valid;
      s1_last  <= i_d_valid & i_d_last;
      s1_err   <= i_d_valid & (i_d_last != at_end);
      if (i_d_valid) begin
        s1_p     <= p;
        s1_first <= first;
        s1_mode  <= m1;
      end
    end

  // Add the carried tail of the previous beat; even lag-2 phases use the second-to-last value
  always_comb begin
    lag2 = s1_mode == MODE_16_LAG2;
    idx  = s1_mode == MODE_32_LAG1 ? IW'(HB - 1) : IW'(BURST_LEN - 1);
    for (int i = 0; i < BURST_LEN; i++) y[i] = s1_p[i] + (s1_first ? '0 : lag2 && i % 2 == 0 ? cl2 : cl1);
  end

  for (genvar g = 0; g < BURST_LEN; g++) begin : g_lane
    rsp_s1_prep_integ_lane_sat #(.ACC_W(ACC_W), .LW(LW), .HI(g % 2)) u_sat (
      .acc  (s1_mode == MODE_32_LAG1 ? y[g / 2] : y[g]),
      .mode (s1_mode),
      .lane (yo[g]),
      .sat  (ss[g])
    );
  end

  // Stage 2 register: saturated outputs and the unsaturated carry for the next beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_y         <= '{default: '0};
      o_y_valid   <= 1'b0;
      o_y_last    <= 1'b0;
      o_sat       <= 1'b0;
      o_frame_err <= 1'b0;
      cl1         <= '0;
      cl2         <= '0;
    end else begin
      o_y_valid   <= s1_valid;
      o_y_last    <= s1_last;
      o_sat       <= s1_valid & (|ss);
      o_frame_err <= s1_err;
      if (s1_valid) begin
        o_y <= yo;
        cl1 <= y[idx];
        cl2 <= y[idx - 1'b1];
      end
    end
endmodule

// File: tb/tb_rsp_s1_prep_integ.sv
// tb_rsp_s1_prep_integ: random and directed bursts checked against a sample-recurrence model
module tb_rsp_s1_prep_integ;
  localparam int DN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_sel_16_32 = 1'b0;
  logic        i_switch = 1'b0;
  logic [15:0] i_d_data [8] = '{default: '0};
  logic        i_d_valid = 1'b0;
  logic        i_d_last = 1'b0;
  logic [15:0] o_y [8];
  logic        o_y_valid, o_y_last, o_sat, o_frame_err;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [127:0] y;
    logic         sat;
    logic         last;
    logic         err;
  } exp_t;

  exp_t        q[$];
  exp_t        le, ce;
  longint      hist[$];
  int          m_cnt = 0;
  int          m_mode = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] dd [8];

  rsp_s1_prep_integ #(.SAMPLE_WIDTH(32), .BURST_LEN(8), .DATA_NUM(DN), .ACC_W(48)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sel_16_32 (i_sel_16_32),
    .i_switch    (i_switch),
    .i_d_data    (i_d_data),
    .i_d_valid   (i_d_valid),
    .i_d_last    (i_d_last),
    .o_y         (o_y),
    .o_y_valid   (o_y_valid),
    .o_y_last    (o_y_last),
    .o_sat       (o_sat),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endfunction

  function automatic logic [127:0] pk(input logic [15:0] a [8]);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = a[i];
    return r;
  endfunction

  // Reference: y[n] = y[n-L] + d[n] over the frame's sample history, clamped symmetrically
  task automatic model(input logic l, input logic sel, input logic sw);
    exp_t   e;
    int     lag, ns;
    longint d, yv, hi;
    if (m_cnt == 0) begin
      m_mode = sel ? 2 : sw ? 1 : 0;
      hist.delete();
    end
    lag = m_mode == 0 ? 2 : 1;
    ns = m_mode == 2 ? 4 : 8;
    hi = m_mode == 2 ? 64'h7FFF_FFFF : 64'h7FFF;
    e = '0;
    for (int k = 0; k < ns; k++) begin
      d = m_mode == 2 ? longint'($signed({dd[2*k+1], dd[2*k]})) : longint'($signed(dd[k]));
      yv = d + (hist.size() >= lag ? hist[hist.size() - lag] : 64'sd0);
      hist.push_back(yv);
      if (yv > hi) begin yv = hi; e.sat = 1'b1; end
      if (yv < -hi) begin yv = -hi; e.sat = 1'b1; end
      if (m_mode == 2) e.y[32*k +: 32] = yv[31:0];
      else e.y[16*k +: 16] = yv[15:0];
    end
    e.last = l;
    e.err = l != (m_cnt == DN - 1);
    m_cnt = (l || m_cnt == DN - 1) ? 0 : m_cnt + 1;
    e.cyc = 32'(cyc + 2);
    q.push_back(e);
    le = e;
  endtask

  task automatic send(input logic v, input logic l, input logic sel, input logic sw);
    @(posedge clk);
    #1;
    i_d_valid = v;
    i_d_last = v & l;
    i_sel_16_32 = sel;
    i_switch = sw;
    i_d_data = dd;
    if (v) model(l, sel, sw);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_d_valid = 1'b0;
    i_d_last = 1'b0;
    rst_n = 1'b0;
    q.delete();
    hist.delete();
    m_cnt = 0;
    #1;
    chk("rst_ctrl", {o_y_valid, o_y_last, o_sat, o_frame_err}, '0);
    chk("rst_y", pk(o_y), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) dd[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
  endtask

  // Single checker: every cycle the output either matches the due expectation or is idle
  always @(negedge clk) if (rst_n) begin
    if (q.size() > 0 && q[0].cyc < 32'(cyc)) begin
      chk("lost_beat_cycle", 128'(q[0].cyc), 128'(cyc));
      ce = q.pop_front();
    end
    if (q.size() > 0 && q[0].cyc == 32'(cyc)) begin
      ce = q.pop_front();
      chk("valid", 128'(o_y_valid), 128'(1));
      chk("y", pk(o_y), ce.y);
      chk("sat", 128'(o_sat), 128'(ce.sat));
      chk("last", 128'(o_y_last), 128'(ce.last));
      chk("frame_err", 128'(o_frame_err), 128'(ce.err));
    end else begin
      chk("idle", 128'({o_y_valid, o_y_last, o_sat, o_frame_err}), '0);
    end
  end

  initial begin
    dd = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("init_ctrl", {o_y_valid, o_y_last, o_sat, o_frame_err}, '0);
    chk("init_y", pk(o_y), '0);
    rst_n = 1'b1;
    dd = '{default: 16'd1};
    for (int b = 0; b < 4; b++) begin
      send(1, b == 3, 0, 0);
      if (b == 0) chk("pin_lag2_b0", le.y, 128'h0004_0004_0003_0003_0002_0002_0001_0001);
      if (b == 3) chk("pin_lag2_b3", {le.y, le.last, le.err}, {128'h0010_0010_000F_000F_000E_000E_000D_000D, 2'b10});
    end
    dd = '{default: 16'h1000};
    for (int b = 0; b < 16; b++) begin
      send(1, b % 4 == 3, 0, 1);
      if (b == 0) chk("pin_lag1_pos", {le.y, le.sat}, {128'h7FFF_7000_6000_5000_4000_3000_2000_1000, 1'b1});
    end
    dd = '{default: 16'hF000};
    for (int b = 0; b < 4; b++) begin
      send(1, b == 3, 0, 1);
      if (b == 0) chk("pin_lag1_neg", {le.y, le.sat}, {128'h8001_9000_A000_B000_C000_D000_E000_F000, 1'b1});
    end
    for (int i = 0; i < 8; i++) dd[i] = i % 2 ? 16'h7FFF : 16'hFFFF;
    for (int b = 0; b < 4; b++) begin
      send(1, b == 3, 1, 0);
      if (b == 0) chk("pin_32_b0", {le.y, le.sat}, {128'h7FFFFFFF_7FFFFFFF_7FFFFFFF_7FFFFFFF, 1'b1});
    end
    for (int b = 0; b < 4; b++) begin
      rand_data();
      send(1, b == 3, 0, b != 0);
    end
    dd = '{default: 16'd1};
    send(1, 0, 0, 1);
    chk("pin_b2b_fresh", le.y, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    for (int b = 1; b < 4; b++) begin
      rand_data();
      send(1, b == 3, 1, 0);
    end
    for (int b = 0; b < 3; b++) begin
      rand_data();
      send(1, b == 2, 0, 1);
      send(0, 0, 0, 1);
    end
    chk("pin_early_last", {le.last, le.err}, 2'b11);
    dd = '{default: 16'd1};
    send(1, 0, 0, 1);
    chk("pin_restart", le.y, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    for (int b = 1; b < 4; b++) begin
      rand_data();
      send(0, 0, 0, 0);
      send(1, 0, 0, 0);
    end
    chk("pin_missing_last", {le.last, le.err}, 2'b01);
    rand_data();
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    do_reset();
    dd = '{default: 16'd1};
    send(1, 0, 0, 1);
    chk("pin_after_rst", le.y, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    for (int b = 1; b < 4; b++) send(1, b == 3, 0, 1);
    for (int n = 0; n < 400; n++) begin
      rand_data();
      send($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom));
    end
    send(0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("drain", 128'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
